// File: rtl/seq_mult21x13_accum.sv
// seq_mult21x13_accum
// Sequential MSB-first shift-add multiplier: unsigned MCAND_W x MPLR_W -> ACC_W product.
// One multiplier bit is consumed per clock. The operand side and the product side
// each use a valid/ready handshake. A new operand pair can be accepted in the same
// cycle that a finished product is taken, so back-to-back operations have no idle bubble.
module seq_mult21x13_accum #(
    parameter int MCAND_W = 21,
    parameter int MPLR_W  = 13,
    parameter int ACC_W   = MCAND_W + MPLR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MCAND_W-1:0] in_mcand,
    input  logic [MPLR_W-1:0]  in_mplr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_product,
    output logic               busy
);

    // The iteration counter must be able to hold MPLR_W itself.
    localparam int CNT_W = $clog2(MPLR_W + 1);
    // Zero-extension width that brings the multiplicand up to the adder width.
    localparam int PAD_W = ACC_W + 1 - MCAND_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Operand and accumulator registers.
    logic [ACC_W-1:0]   acc;
    logic [MCAND_W-1:0] mcand;
    logic [MPLR_W-1:0]  mplr;
    logic [CNT_W-1:0]   cnt;

    // Accumulate stage: 34-bit shifted accumulator plus a zero-extended 21-bit addend.
    logic               mplr_bit;
    logic [ACC_W:0]     shifted;
    logic [ACC_W:0]     addend;
    logic [ACC_W:0]     sum35;
    // The carry out of the accumulate adder is provably zero, so it is discarded.
    logic               unused_carry;

    // Handshake helpers.
    logic               accept;
    logic               last_step;

    // Current multiplier bit, MSB first.
    assign mplr_bit = mplr[MPLR_W-1];

    // acc < 2^(MCAND_W+k) after k steps, so dropping acc's MSB in the shift loses nothing.
    assign shifted  = {1'b0, acc[ACC_W-2:0], 1'b0};

    // Addend is the multiplicand when the current bit is set, zero otherwise.
    assign addend   = {{PAD_W{1'b0}}, (mplr_bit ? mcand : {MCAND_W{1'b0}})};

    assign sum35        = shifted + addend;
    assign unused_carry = sum35[ACC_W];

    // The final iteration is the one performed while cnt is 1.
    assign last_step = (cnt == CNT_W'(1));

    // An operand pair is taken whenever both sides of the input handshake agree.
    assign accept = in_valid && in_ready;

    // The product register doubles as the accumulator; it is only meaningful while out_valid.
    assign out_product = acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Product taken: restart immediately if new operands wait, else go idle.
                if (out_ready) begin
                    state_nxt = in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the current state (in_ready also depends on out_ready in DONE).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                busy = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                // Accepting new operands only when the current product is consumed
                // keeps the product stable under backpressure.
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on accept, otherwise run one shift-add step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc   <= '0;
            mcand <= in_mcand;
            mplr  <= in_mplr;
            cnt   <= CNT_W'(MPLR_W);
        end else if (state == BUSY) begin
            acc   <= sum35[ACC_W-1:0];
            mplr  <= {mplr[MPLR_W-2:0], 1'b0};
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_mult21x13_accum.sv
// tb_seq_mult21x13_accum
// Directed bench for the 21x13 sequential multiplier. A transaction-level model
// (plain multiplication plus a fixed 13-cycle latency) is compared against the
// DUT every cycle; directed tests also check hand-computed products and latencies.
module tb_seq_mult21x13_accum;

    localparam int MCAND_W = 21;
    localparam int MPLR_W  = 13;
    localparam int ACC_W   = 34;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [MCAND_W-1:0] in_mcand;
    logic [MPLR_W-1:0]  in_mplr;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_product;
    logic               busy;

    int errors = 0;
    int checks = 0;

    seq_mult21x13_accum dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mcand   (in_mcand),
        .in_mplr    (in_mplr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .busy       (busy)
    );

    // 10-unit clock, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: an accepted pair yields a*b exactly 13 edges later and is
    // held until consumed. m_phase: 0 waiting for operands, 1 computing, 2 holding result.
    int               m_phase = 0;
    int               m_left  = 0;
    logic [ACC_W-1:0] m_pending = '0;
    logic [ACC_W-1:0] m_prod    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pending = ACC_W'(in_mcand) * ACC_W'(in_mplr);
                    m_left    = MPLR_W;
                    m_phase   = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_prod  = m_pending;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) begin
                    if (in_valid) begin
                        m_pending = ACC_W'(in_mcand) * ACC_W'(in_mplr);
                        m_left    = MPLR_W;
                        m_phase   = 1;
                    end else begin
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_out_valid", ACC_W'(out_valid), ACC_W'(m_phase == 2));
            check("mdl_busy", ACC_W'(busy), ACC_W'(m_phase == 1));
            check("mdl_in_ready", ACC_W'(in_ready),
                  ACC_W'((m_phase == 0) || (m_phase == 2 && out_ready)));
            if (m_phase == 2) check("mdl_product", out_product, m_prod);
            if (busy) check("sum35_msb_zero", ACC_W'(dut.sum35[ACC_W]), '0);
        end
    end

    // Inputs change 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in an accepting state for one edge, scramble them afterwards
    // (they must be ignored while busy), then wait for the product.
    task automatic run_op(input logic [MCAND_W-1:0] a, input logic [MPLR_W-1:0] b,
                          input logic [ACC_W-1:0] exp, input string name);
        int n;
        in_mcand = a;
        in_mplr  = b;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mcand  = MCAND_W'($urandom);
        in_mplr   = MPLR_W'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, ACC_W'(n), ACC_W'(13));
        check({name, "_product"}, out_product, exp);
    endtask

    task automatic release_product();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mcand  = '0;
        in_mplr   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", ACC_W'(out_valid), '0);
        check("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
        check("rst_busy", ACC_W'(busy), '0);
        check("rst_product", out_product, '0);
        tick();

        // Basic product and latency.
        run_op(21'd3, 13'd5, 34'h00000000F, "t1_3x5");
        release_product();

        // Largest operands.
        run_op(21'h1FFFFF, 13'h1FFF, 34'h3FFDFE001, "t2_max");
        release_product();

        // Zero operands still run the full iteration count.
        run_op(21'h12345, 13'h0, 34'h0, "t3_mplr0");
        release_product();
        run_op(21'h0, 13'h1ABC, 34'h0, "t3_mcand0");
        release_product();

        // Backpressure: product held for 20 cycles, then consumed into IDLE.
        run_op(21'd6, 13'd7, 34'd42, "t4_bp");
        for (int i = 0; i < 20; i++) tick();
        check("t4_hold_valid", ACC_W'(out_valid), ACC_W'(1));
        check("t4_hold_product", out_product, 34'd42);
        check("t4_hold_in_ready", ACC_W'(in_ready), '0);
        release_product();
        check("t4_idle_valid", ACC_W'(out_valid), '0);
        check("t4_idle_in_ready", ACC_W'(in_ready), ACC_W'(1));

        // Back-to-back: second pair accepted in the DONE cycle that consumes the first.
        run_op(21'd4, 13'd5, 34'd20, "t5_first");
        in_mcand  = 21'd7;
        in_mplr   = 13'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t5_in_ready_in_done", ACC_W'(in_ready), ACC_W'(1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        begin
            int n;
            n = 1;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            check("t5_gap", ACC_W'(n), ACC_W'(14));
            check("t5_second_product", out_product, 34'd63);
        end
        release_product();

        // Reset in the 6th busy cycle aborts the operation.
        in_mcand = 21'd11;
        in_mplr  = 13'd13;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_busy_before_rst", ACC_W'(busy), ACC_W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", ACC_W'(out_valid), '0);
        check("t6_in_ready", ACC_W'(in_ready), ACC_W'(1));
        check("t6_busy", ACC_W'(busy), '0);
        run_op(21'd2, 13'd2, 34'd4, "t6_restart");
        release_product();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
